// File: rtl/tri_bbox_scanner_pkg.sv
// tri_bbox_scanner_pkg: shared graphics types, the edge function and bbox helpers
package tri_bbox_scanner_pkg;

   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
   } int_point;

   typedef struct packed {
      int_point a;
      int_point b;
      int_point c;
   } int_triangle;

   // Signed area term of p against edge a->b; >= 0 means p is on the inner side for CCW triangles.
   function automatic logic signed [63:0] edge_fn(input int_point a, input int_point b, input int_point p);
      logic signed [63:0] dx_ab, dy_ab, dx_ap, dy_ap;
      dx_ab = 64'(b.x) - 64'(a.x);
      dy_ab = 64'(b.y) - 64'(a.y);
      dx_ap = 64'(p.x) - 64'(a.x);
      dy_ap = 64'(p.y) - 64'(a.y);
      return dx_ab * dy_ap - dy_ab * dx_ap;
   endfunction

   function automatic logic signed [31:0] min3(input logic signed [31:0] a, input logic signed [31:0] b,
                                               input logic signed [31:0] c);
      logic signed [31:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic signed [31:0] max3(input logic signed [31:0] a, input logic signed [31:0] b,
                                               input logic signed [31:0] c);
      logic signed [31:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Clamp a signed coordinate into 0..hi.
   function automatic logic signed [31:0] clamp(input logic signed [31:0] v, input int hi);
      return (v < 0) ? 32'sd0 : (v > hi) ? 32'(hi) : v;
   endfunction

endpackage

// File: rtl/tri_bbox_scanner.sv
// tri_bbox_scanner: walks a triangle's screen-clamped bounding box in raster order and emits covered pixels
module tri_bbox_scanner
   import tri_bbox_scanner_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        tri_valid,
   output logic                        tri_ready,
   input  int_triangle                 tri_in,
   output int_triangle                 test_tri,
   output int_point                    test_point,
   input  logic                        point_in_tri,
   output logic                        pix_valid,
   input  logic                        pix_ready,
   output logic [$clog2(SCREEN_W)-1:0] pix_x,
   output logic [$clog2(SCREEN_H)-1:0] pix_y,
   output logic                        done
);

   localparam int XW = $clog2(SCREEN_W);
   localparam int YW = $clog2(SCREEN_H);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

   state_t             state, state_nx;
   logic signed [31:0] raw_min_x, raw_max_x, raw_min_y, raw_max_y;
   logic [XW-1:0]      clp_min_x, clp_max_x, min_x, max_x, cur_x;
   logic [YW-1:0]      clp_min_y, clp_max_y, max_y, cur_y;
   logic               off_screen, adv, last_pt;

   // Bounding box of the captured triangle, raw for the off-screen test and clamped for scanning
   always_comb begin
      raw_min_x  = min3(test_tri.a.x, test_tri.b.x, test_tri.c.x);
      raw_max_x  = max3(test_tri.a.x, test_tri.b.x, test_tri.c.x);
      raw_min_y  = min3(test_tri.a.y, test_tri.b.y, test_tri.c.y);
      raw_max_y  = max3(test_tri.a.y, test_tri.b.y, test_tri.c.y);
      clp_min_x  = XW'(clamp(raw_min_x, SCREEN_W - 1));
      clp_max_x  = XW'(clamp(raw_max_x, SCREEN_W - 1));
      clp_min_y  = YW'(clamp(raw_min_y, SCREEN_H - 1));
      clp_max_y  = YW'(clamp(raw_max_y, SCREEN_H - 1));
      off_screen = raw_max_x < 0 || raw_max_y < 0 || raw_min_x > SCREEN_W - 1 || raw_min_y > SCREEN_H - 1;
   end

   // Next-state logic; a candidate advances unless a covered pixel is being stalled
   always_comb begin
      state_nx = state;
      adv      = state == SCAN && (!point_in_tri || pix_ready);
      last_pt  = cur_x == max_x && cur_y == max_y;
      case (state)
         IDLE:    state_nx = tri_valid ? SETUP : IDLE;
         SETUP:   state_nx = off_screen ? DONE : SCAN;
         SCAN:    state_nx = (adv && last_pt) ? DONE : SCAN;
         default: state_nx = IDLE;
      endcase
   end

   // State register; reset aborts any triangle in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Triangle capture, bbox latch and raster walk of the candidate point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         test_tri <= '0;
         min_x    <= '0;
         max_x    <= '0;
         max_y    <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
      end else begin
         if (state == IDLE && tri_valid) test_tri <= tri_in;
         if (state == SETUP) begin
            min_x <= clp_min_x;
            max_x <= clp_max_x;
            max_y <= clp_max_y;
            cur_x <= clp_min_x;
            cur_y <= clp_min_y;
         end else if (adv && !last_pt) begin
            cur_x <= (cur_x == max_x) ? min_x : cur_x + 1'b1;
            cur_y <= (cur_x == max_x) ? cur_y + 1'b1 : cur_y;
         end
      end
   end

   assign tri_ready  = state == IDLE;
   assign pix_valid  = state == SCAN && point_in_tri;
   assign done       = state == DONE;
   assign pix_x      = cur_x;
   assign pix_y      = cur_y;
   assign test_point = '{x: {{(32 - XW){1'b0}}, cur_x}, y: {{(32 - YW){1'b0}}, cur_y}};

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// tb_tri_bbox_scanner: directed triangles with a pixel/done scoreboard checked by an independent monitor
module tb_tri_bbox_scanner;
   import tri_bbox_scanner_pkg::*;

   localparam int W = 64;
   localparam int H = 48;

   typedef struct {
      int x;
      int y;
   } px_t;

   logic        clk, rst_n, tri_valid, tri_ready, point_in_tri, pix_valid, pix_ready, done;
   int_triangle tri_in, test_tri;
   int_point    test_point;
   logic [5:0]  pix_x;
   logic [5:0]  pix_y;

   px_t exp_px[$];
   int  exp_done[$];
   int  cyc = 0, passed = 0, total = 0;
   bit  bp = 0;

   tri_bbox_scanner #(.SCREEN_W(W), .SCREEN_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_in(tri_in),
      .test_tri(test_tri), .test_point(test_point), .point_in_tri(point_in_tri),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .done(done)
   );

   // External point tester: CCW triangles only, inner side inclusive
   assign point_in_tri = edge_fn(test_tri.a, test_tri.b, test_tri.c) > 0 &&
                         edge_fn(test_tri.a, test_tri.b, test_point) >= 0 &&
                         edge_fn(test_tri.b, test_tri.c, test_point) >= 0 &&
                         edge_fn(test_tri.c, test_tri.a, test_point) >= 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1, "timeout");
   end

   task automatic check(input bit ok, input string nm, input int act, input int req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, required %0d", nm, act, req);
   endtask

   function automatic int_triangle mk(input int ax, input int ay, input int bx, input int by,
                                      input int cx, input int cy);
      int_triangle t;
      t.a.x = ax; t.a.y = ay;
      t.b.x = bx; t.b.y = by;
      t.c.x = cx; t.c.y = cy;
      return t;
   endfunction

   task automatic push_px(input int x, input int y);
      px_t p;
      p.x = x;
      p.y = y;
      exp_px.push_back(p);
   endtask

   // Pixels of (2,2),(5,2),(2,5): x>=2, y>=2, x+y<=7, in raster order
   task automatic push_small();
      for (int y = 2; y <= 5; y++)
         for (int x = 2; x <= 5; x++)
            if (x + y <= 7) push_px(x, y);
   endtask

   // Offer a triangle; lat is the expected accept-to-done distance in cycles, -1 if not fixed
   task automatic send(input int_triangle t, input int lat);
      int n = 0;
      while (!tri_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check(tri_ready, "tri_ready_before_send", tri_ready, 1);
      tri_in    = t;
      tri_valid = 1;
      @(posedge clk); #1;
      tri_valid = 0;
      exp_done.push_back(lat < 0 ? -1 : cyc + lat);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (exp_done.size() != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check(exp_done.size() == 0, "done_seen", exp_done.size(), 0);
      check(exp_px.size() == 0, "pixels_remaining", exp_px.size(), 0);
      exp_done.delete();
      exp_px.delete();
   endtask

   // Downstream ready: always 1, or the repeating 1,0,0,1 pattern when bp is set
   initial begin
      int ph = 0;
      pix_ready = 1;
      forever begin
         @(posedge clk); #1;
         if (bp) begin
            pix_ready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
         end else pix_ready = 1;
      end
   end

   // Monitor: pops expected pixels/done pulses and checks stall stability
   initial begin
      px_t  e;
      int   d;
      bit   stall_prev = 0;
      int   px_prev = 0, py_prev = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) stall_prev = 0;
         else begin
            if (stall_prev)
               check(pix_valid && pix_x == px_prev && pix_y == py_prev, "stall_hold",
                     int'(pix_x) * 1000 + int'(pix_y), px_prev * 1000 + py_prev);
            if (pix_valid && pix_ready) begin
               if (exp_px.size() == 0) check(0, "pixel_unexpected", int'(pix_x) * 1000 + int'(pix_y), -1);
               else begin
                  e = exp_px.pop_front();
                  check(pix_x == e.x && pix_y == e.y, "pixel_xy",
                        int'(pix_x) * 1000 + int'(pix_y), e.x * 1000 + e.y);
               end
            end
            if (done) begin
               if (exp_done.size() == 0) check(0, "done_unexpected", cyc, -1);
               else begin
                  d = exp_done.pop_front();
                  if (d >= 0) check(cyc == d, "done_latency", cyc, d);
               end
            end
            stall_prev = pix_valid && !pix_ready;
            px_prev    = pix_x;
            py_prev    = pix_y;
         end
      end
   end

   initial begin
      rst_n     = 0;
      tri_valid = 0;
      tri_in    = '0;
      #1;
      check(tri_ready == 1, "reset_tri_ready", tri_ready, 1);
      check(pix_valid == 0, "reset_pix_valid", pix_valid, 0);
      check(done == 0, "reset_done", done, 0);
      check(pix_x == 0 && pix_y == 0, "reset_pix_xy", int'(pix_x) * 1000 + int'(pix_y), 0);
      check(test_point == '0, "reset_test_point", int'(test_point.x), 0);
      check(test_tri == '0, "reset_test_tri", int'(test_tri.a.x), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      check(tri_ready == 1, "release_tri_ready", tri_ready, 1);

      // CCW right triangle: 16 candidates, 10 pixels, done 18 cycles after acceptance
      push_small();
      send(mk(2, 2, 5, 2, 2, 5), 18);
      wait_done(100);

      // Same triangle, clockwise: scanned but nothing emitted
      send(mk(2, 2, 2, 5, 5, 2), 18);
      wait_done(100);

      // Completely off-screen: SETUP straight to DONE
      send(mk(700, 700, 800, 700, 700, 800), 2);
      wait_done(20);

      // Covers the whole screen: every clamped point emitted
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) push_px(x, y);
      send(mk(-10, -10, 700, -10, -10, 500), W * H + 2);
      wait_done(W * H + 50);

      // Backpressure 1,0,0,1: same pixel set, held stable while stalled
      bp = 1;
      push_small();
      send(mk(2, 2, 5, 2, 2, 5), -1);
      wait_done(200);
      bp = 0;
      @(posedge clk); #1;

      // Reset during the fifth SCAN cycle: only the first four pixels ever appear
      for (int x = 2; x <= 5; x++) push_px(x, 2);
      check(tri_ready, "tri_ready_before_abort", tri_ready, 1);
      tri_in    = mk(2, 2, 5, 2, 2, 5);
      tri_valid = 1;
      @(posedge clk); #1;
      tri_valid = 0;
      repeat (5) @(posedge clk);
      #2 rst_n = 0;
      #1;
      check(pix_valid == 0, "abort_pix_valid", pix_valid, 0);
      check(done == 0, "abort_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1;
      #1;
      check(tri_ready == 1, "abort_tri_ready", tri_ready, 1);
      check(exp_px.size() == 0, "abort_pixels_before_reset", exp_px.size(), 0);
      exp_px.delete();

      // A fresh triangle after the abort scans normally
      push_small();
      send(mk(2, 2, 5, 2, 2, 5), 18);
      wait_done(100);

      repeat (5) @(posedge clk);
      #1;
      check(exp_px.size() == 0 && exp_done.size() == 0, "final_queues_empty", exp_px.size() + exp_done.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tri_bbox_scanner.md
TRI_BBOX_SCANNER -- requirements
Module: tri_bbox_scanner

Interface
REQ-001 Parameter SCREEN_W, default 640, screen width in pixels; legal x is 0..SCREEN_W-1.
REQ-002 Parameter SCREEN_H, default 480, screen height in pixels; legal y is 0..SCREEN_H-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tri_valid  input  1  upstream triangle available.
REQ-006 tri_ready  output  1  scanner can accept a triangle; high only in IDLE.
REQ-007 tri_in  input  int_triangle  triangle (vertices a, b, c; signed 32-bit int_point each).
REQ-008 test_tri  output  int_triangle  registered copy of the accepted triangle, to the point tester.
REQ-009 test_point  output  int_point  current candidate point, to the point tester.
REQ-010 point_in_tri  input  1  combinational tester verdict for test_point/test_tri in the same cycle.
REQ-011 pix_valid  output  1  covered pixel offered downstream.
REQ-012 pix_ready  input  1  downstream accepts pixel.
REQ-013 pix_x / pix_y  output  $clog2(SCREEN_W) / $clog2(SCREEN_H)  unsigned pixel coordinates.
REQ-014 done  output  1  one-cycle pulse: triangle fully scanned.

Function
REQ-015 FSM states IDLE, SETUP, SCAN, DONE.
REQ-016 IDLE: tri_valid && tri_ready captures tri_in into test_tri; next state SETUP.
REQ-017 SETUP (one cycle): bbox = min/max of vertex x and y, signed compare, each clamped to [0, SCREEN_W-1] / [0, SCREEN_H-1]; cur_x = min_x, cur_y = min_y.
REQ-018 SETUP: if unclamped max_x < 0, max_y < 0, min_x > SCREEN_W-1 or min_y > SCREEN_H-1, next state DONE without entering SCAN; else SCAN.
REQ-019 SCAN: test_point = (cur_x, cur_y) zero-extended to signed 32-bit; pix_valid = point_in_tri; pix_x = cur_x, pix_y = cur_y.
REQ-020 SCAN advances when !pix_valid || pix_ready: x increments; at x == max_x, x wraps to min_x and y increments.
REQ-021 Advancing from (max_x, max_y) moves to DONE; no further points presented.
REQ-022 When pix_valid && !pix_ready, cur_x, cur_y, pix_x, pix_y hold stable; pix_valid stays asserted until accepted.
REQ-023 Throughput: one candidate point per cycle without backpressure; first point in the second cycle after acceptance.
REQ-024 DONE: done = 1 for exactly one cycle; next state IDLE; tri_ready rises in the following cycle.
REQ-025 pix_valid is 0 in every state except SCAN; done is 0 except in DONE.
REQ-026 Degenerate triangles (abc <= 0) are still scanned; the tester rejects every point, so no pixels are produced.

Reset
REQ-027 rst_n low forces IDLE immediately, at any time, including mid-SCAN; the in-flight triangle is discarded.
REQ-028 Reset values: tri_ready 1 after release, pix_valid 0, done 0, pix_x 0, pix_y 0, test_point (0,0), test_tri all zero, bbox and counters 0.

Structure
REQ-029 int_point, int_triangle and edge_fn stay in the shared graphics include; the FSM state enum is local to this module.
REQ-030 tri_point_tester is instantiated outside this block and wired between test_point/test_tri and point_in_tri; tri_bbox_scanner contains no sub-modules.

Verification
REQ-031 Triangle a=(2,2), b=(5,2), c=(2,5) with pix_ready=1: SCAN lasts 16 cycles. Points run (2,2)..(5,5) in raster order. The emitted pixel set equals the model's set of points with all edge_fn >= 0 and abc > 0. done pulses 18 cycles after acceptance.
REQ-032 Same triangle with b and c swapped: 16 points scanned, 0 pixels emitted, done still pulses once.
REQ-033 Triangle (-10,-10), (700,-10), (-10,500): bbox clamps to x 0..639 and y 0..479, giving 307200 points scanned. No pix_x >= 640 or pix_y >= 480 is emitted.
REQ-034 Triangle (700,700), (800,700), (700,800): no SCAN state; done pulses 2 cycles after acceptance; no pixels emitted.
REQ-035 REQ-031 triangle with pix_ready toggling 1,0,0,1 repeating: same pixel set, no pixels duplicated or dropped, pix_x/pix_y stable while stalled.
REQ-036 rst_n pulsed low on the 5th SCAN cycle: pix_valid drops asynchronously. After release tri_ready is 1, and a new triangle scans correctly.
